// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: stage indices, FSM encodings, stall/bubble patterns.
// Latency: n/a (constants only). Backpressure: n/a.
// Stall/bubble patterns are built from stage indices so they track any stage renumbering.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned STG_IF  = 0;
    localparam int unsigned STG_ID  = 1;
    localparam int unsigned STG_EX  = 2;
    localparam int unsigned STG_MEM = 3;
    localparam int unsigned STG_WB  = 4;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DWAIT = 1'b1;

    localparam logic [4:0] STALL_FETCH = 5'b1 << STG_IF;
    localparam logic [4:0] BUB_FETCH   = 5'b1 << STG_ID;
    localparam logic [4:0] STALL_FLUSH = 5'b0;
    localparam logic [4:0] BUB_FLUSH   = 5'b1 << STG_ID;
    localparam logic [4:0] STALL_LOAD  = (5'b1 << STG_IF) | (5'b1 << STG_ID);
    localparam logic [4:0] BUB_LOAD    = 5'b1 << STG_EX;
    localparam logic [4:0] STALL_BR    = STALL_LOAD;
    localparam logic [4:0] BUB_BR      = BUB_LOAD;
    localparam logic [4:0] STALL_DWAIT = STALL_LOAD | (5'b1 << STG_EX) | (5'b1 << STG_MEM);
    localparam logic [4:0] BUB_DWAIT   = 5'b1 << STG_WB;
    localparam logic [4:0] BUB_RESET   = 5'b11111;

    typedef enum logic [2:0] {
        RULE_NONE,
        RULE_DWAIT,
        RULE_LOAD,
        RULE_BR,
        RULE_FLUSH,
        RULE_FETCH
    } hz_rule_e;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
// Latency: count visible the cycle after inc. Backpressure: none.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble generation for the 5-stage pipe, data-memory wait FSM with timeout, perf counters.
// Latency: stall/bubble combinational from inputs and FSM state. Backpressure: holds stages via stall.
// Counters saturate; timeout flag is sticky until reset.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int CNT_W        = 32,
    parameter int DMEM_TIMEOUT = 255,
    parameter int ID_BRANCH    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_ready,
    input  logic              dmem_ready,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic              use_rs1_id,
    input  logic              use_rs2_id,
    input  logic              branch_id,
    input  logic              jal_id,
    input  logic              jalr_id,
    input  logic              pc_src_id,
    input  logic              reg_write_ex,
    input  logic              mem_read_ex,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic              mem_read_mem,
    input  logic              mem_write_mem,
    input  logic [REG_AW-1:0] rd_mem,
    output logic [4:0]        stall,
    output logic [4:0]        bubble,
    output logic              dmem_timeout_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int              WAIT_W    = $clog2(DMEM_TIMEOUT + 2);
    localparam bit              TO_EN     = (DMEM_TIMEOUT != 0);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(DMEM_TIMEOUT);

    // x0 is hardwired zero, so it can never carry a real dependency.
    function automatic logic reg_hit(input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs,
                                     input logic              use_rs);
        return use_rs && (rs == rd) && (rd != '0);
    endfunction

    logic [0:0]        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_acc;
    logic              abort_now;
    logic              hit_ex;
    logic              hit_mem;
    logic              br_ctrl;
    hz_rule_e          rule;
    logic [4:0]        stall_c;
    logic [4:0]        bubble_c;
    logic              flush_hit;
    logic              unused_jal;

    // jal has no register sources, so it never creates an ID-operand hazard.
    assign unused_jal = jal_id;

    assign mem_acc   = mem_read_mem | mem_write_mem;
    assign abort_now = TO_EN && (state == ST_DWAIT) && !dmem_ready && (wait_cnt == TIMEOUT_V);
    assign hit_ex    = reg_hit(rd_ex, rs1_id, use_rs1_id) | reg_hit(rd_ex, rs2_id, use_rs2_id);
    assign hit_mem   = reg_hit(rd_mem, rs1_id, use_rs1_id) | reg_hit(rd_mem, rs2_id, use_rs2_id);
    assign br_ctrl   = (ID_BRANCH != 0) && (branch_id || jalr_id);

    always_comb begin
        rule = RULE_NONE;
        if (mem_acc && !dmem_ready && !abort_now) begin
            rule = RULE_DWAIT;
        end else if (mem_read_ex && hit_ex) begin
            rule = RULE_LOAD;
        end else if (br_ctrl && ((reg_write_ex && hit_ex) || (mem_read_mem && hit_mem))) begin
            rule = RULE_BR;
        end else if (pc_src_id) begin
            rule = RULE_FLUSH;
        end else if (!imem_ready) begin
            rule = RULE_FETCH;
        end
    end

    always_comb begin
        stall_c   = '0;
        bubble_c  = '0;
        flush_hit = 1'b0;
        case (rule)
            RULE_DWAIT: begin stall_c = STALL_DWAIT; bubble_c = BUB_DWAIT; end
            RULE_LOAD:  begin stall_c = STALL_LOAD;  bubble_c = BUB_LOAD;  end
            RULE_BR:    begin stall_c = STALL_BR;    bubble_c = BUB_BR;    end
            RULE_FLUSH: begin stall_c = STALL_FLUSH; bubble_c = BUB_FLUSH; flush_hit = 1'b1; end
            RULE_FETCH: begin stall_c = STALL_FETCH; bubble_c = BUB_FETCH; end
            default:    begin stall_c = '0;          bubble_c = '0;        end
        endcase
    end

    // While reset is asserted every pipe register is forced to a NOP.
    assign stall  = rst ? stall_c  : 5'b0;
    assign bubble = rst ? bubble_c : BUB_RESET;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= ST_RUN;
            wait_cnt         <= '0;
            dmem_timeout_err <= 1'b0;
        end else if (state == ST_RUN) begin
            if (mem_acc && !dmem_ready) begin
                state    <= ST_DWAIT;
                wait_cnt <= WAIT_W'(1);
            end
        end else begin
            if (dmem_ready) begin
                state    <= ST_RUN;
                wait_cnt <= '0;
            end else if (abort_now) begin
                state            <= ST_RUN;
                wait_cnt         <= '0;
                dmem_timeout_err <= 1'b1;
            end else if (wait_cnt != '1) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_c != 5'b0),
        .clear (1'b0),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_hit),
        .clear (1'b0),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scenarios plus randomized traffic against a cycle-level reference model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int REG_AW       = 5;
    localparam int CNT_W        = 4;
    localparam int DMEM_TIMEOUT = 4;
    localparam int ID_BRANCH    = 1;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic              imem_ready, dmem_ready;
    logic [REG_AW-1:0] rs1_id, rs2_id, rd_ex, rd_mem;
    logic              use_rs1_id, use_rs2_id;
    logic              branch_id, jal_id, jalr_id, pc_src_id;
    logic              reg_write_ex, mem_read_ex, mem_read_mem, mem_write_mem;
    logic [4:0]        stall, bubble;
    logic              dmem_timeout_err;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_waited;      // cycles already spent in the current data-memory wait (0 = not waiting)
    bit m_err;
    int m_stall_cnt;
    int m_flush_cnt;

    logic [4:0] last_stall, last_bubble;

    pipe_hazard_ctrl #(
        .REG_AW(REG_AW), .CNT_W(CNT_W), .DMEM_TIMEOUT(DMEM_TIMEOUT), .ID_BRANCH(ID_BRANCH)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
        .branch_id(branch_id), .jal_id(jal_id), .jalr_id(jalr_id), .pc_src_id(pc_src_id),
        .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex), .rd_ex(rd_ex),
        .mem_read_mem(mem_read_mem), .mem_write_mem(mem_write_mem), .rd_mem(rd_mem),
        .stall(stall), .bubble(bubble), .dmem_timeout_err(dmem_timeout_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit id_reads(input logic [REG_AW-1:0] r);
        if (r == 0) return 0;
        return (use_rs1_id && rs1_id == r) || (use_rs2_id && rs2_id == r);
    endfunction

    task automatic set_idle();
        imem_ready = 1; dmem_ready = 1;
        rs1_id = 0; rs2_id = 0; use_rs1_id = 0; use_rs2_id = 0;
        branch_id = 0; jal_id = 0; jalr_id = 0; pc_src_id = 0;
        reg_write_ex = 0; mem_read_ex = 0; rd_ex = 0;
        mem_read_mem = 0; mem_write_mem = 0; rd_mem = 0;
    endtask

    // Called just after a rising edge; checks at the falling edge, then advances the model.
    task automatic cycle();
        logic [4:0] es, eb;
        bit acc, abort, flush;
        @(negedge clk);
        acc   = mem_read_mem || mem_write_mem;
        abort = (DMEM_TIMEOUT != 0) && (m_waited == DMEM_TIMEOUT) && !dmem_ready;
        es = 5'b0; eb = 5'b0; flush = 0;
        if (acc && !dmem_ready && !abort) begin
            es = 5'b01111; eb = 5'b10000;
        end else if (mem_read_ex && id_reads(rd_ex)) begin
            es = 5'b00011; eb = 5'b00100;
        end else if (ID_BRANCH != 0 && (branch_id || jalr_id) &&
                     ((reg_write_ex && id_reads(rd_ex)) || (mem_read_mem && id_reads(rd_mem)))) begin
            es = 5'b00011; eb = 5'b00100;
        end else if (pc_src_id) begin
            eb = 5'b00010; flush = 1;
        end else if (!imem_ready) begin
            es = 5'b00001; eb = 5'b00010;
        end
        chk("stall", stall, es);
        chk("bubble", bubble, eb);
        chk("err", dmem_timeout_err, m_err);
        chk("stall_cnt", stall_cnt, m_stall_cnt);
        chk("flush_cnt", flush_cnt, m_flush_cnt);
        last_stall  = stall;
        last_bubble = bubble;
        @(posedge clk);
        if (es != 0 && m_stall_cnt < CNT_MAX) m_stall_cnt++;
        if (flush && m_flush_cnt < CNT_MAX) m_flush_cnt++;
        if (abort) m_err = 1;
        if (m_waited == 0)              m_waited = (acc && !dmem_ready) ? 1 : 0;
        else if (dmem_ready || abort)   m_waited = 0;
        else                            m_waited++;
        #1;
    endtask

    // Called just after a rising edge; asserts reset asynchronously and checks outputs immediately.
    task automatic apply_reset();
        rst = 0;
        #2;
        chk("rst_stall", stall, 5'b00000);
        chk("rst_bubble", bubble, 5'b11111);
        chk("rst_err", dmem_timeout_err, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        m_waited = 0; m_err = 0; m_stall_cnt = 0; m_flush_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    initial begin
        set_idle();
        apply_reset();

        // Load-use on x5
        set_idle();
        mem_read_ex = 1; reg_write_ex = 1; rd_ex = 5; rs1_id = 5; use_rs1_id = 1;
        cycle();
        chk("lu_stall", last_stall, 5'b00011);
        chk("lu_bubble", last_bubble, 5'b00100);
        set_idle();
        chk("lu_cnt", stall_cnt, 1);
        cycle();

        // ID branch on x7: EX producer, then load in MEM, then redirect
        branch_id = 1; rs1_id = 7; use_rs1_id = 1; reg_write_ex = 1; rd_ex = 7;
        cycle();
        chk("br_ex_stall", last_stall, 5'b00011);
        reg_write_ex = 0; rd_ex = 0; mem_read_mem = 1; rd_mem = 7;
        cycle();
        chk("br_mem_stall", last_stall, 5'b00011);
        set_idle();
        pc_src_id = 1;
        cycle();
        chk("flush_bubble", last_bubble, 5'b00010);
        chk("flush_stall", last_stall, 5'b00000);
        set_idle();
        chk("flush_cnt1", flush_cnt, 1);

        // Store waits three cycles
        mem_write_mem = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("st_wait_stall", last_stall, 5'b01111);
            chk("st_wait_bubble", last_bubble, 5'b10000);
        end
        dmem_ready = 1;
        cycle();
        chk("st_done_stall", last_stall, 5'b00000);
        set_idle();
        chk("st_no_err", dmem_timeout_err, 0);
        cycle();

        // Timeout: stall released on the fifth wait cycle
        mem_read_mem = 1; dmem_ready = 0;
        for (int i = 1; i <= 5; i++) begin
            cycle();
            chk("to_stall", last_stall, (i < 5) ? 5'b01111 : 5'b00000);
        end
        set_idle();
        chk("to_err_set", dmem_timeout_err, 1);
        repeat (3) cycle();
        chk("to_err_sticky", dmem_timeout_err, 1);

        // Redirect beats fetch wait
        imem_ready = 0; pc_src_id = 1;
        cycle();
        chk("redir_bubble", last_bubble, 5'b00010);
        chk("redir_stall", last_stall, 5'b00000);
        pc_src_id = 0;
        cycle();
        chk("fetch_stall", last_stall, 5'b00001);
        chk("fetch_bubble", last_bubble, 5'b00010);

        // Stall counter saturates
        repeat (20) cycle();
        chk("stall_cnt_sat", stall_cnt, CNT_MAX);

        // Reset in the middle of a data wait
        set_idle();
        mem_write_mem = 1; dmem_ready = 0;
        repeat (2) cycle();
        apply_reset();
        repeat (6) cycle();
        set_idle();

        // x0 never matches
        mem_read_ex = 1; reg_write_ex = 1; rd_ex = 0; rs1_id = 0; use_rs1_id = 1;
        cycle();
        chk("x0_stall", last_stall, 5'b00000);
        set_idle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) apply_reset();
            imem_ready    = ($urandom_range(0, 3) != 0);
            dmem_ready    = ($urandom_range(0, 2) != 0);
            rs1_id        = REG_AW'($urandom_range(0, 3));
            rs2_id        = REG_AW'($urandom_range(0, 3));
            rd_ex         = REG_AW'($urandom_range(0, 3));
            rd_mem        = REG_AW'($urandom_range(0, 3));
            use_rs1_id    = 1'($urandom);
            use_rs2_id    = 1'($urandom);
            branch_id     = ($urandom_range(0, 3) == 0);
            jal_id        = ($urandom_range(0, 7) == 0);
            jalr_id       = ($urandom_range(0, 7) == 0);
            pc_src_id     = ($urandom_range(0, 4) == 0);
            reg_write_ex  = 1'($urandom);
            mem_read_ex   = ($urandom_range(0, 3) == 0);
            mem_read_mem  = ($urandom_range(0, 3) == 0);
            mem_write_mem = ($urandom_range(0, 4) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
